// File: rtl/sprite_line_engine.sv
// Scanline sprite renderer: evaluates attribute RAM, fetches two-bitplane tile rows and
// composites them into a double-buffered line buffer read out with clear-on-read.
module sprite_line_engine #(
  parameter int unsigned NUM_SPR      = 32,
  parameter int unsigned MAX_PER_LINE = 16,
  parameter int unsigned COL_BITS     = 3,
  parameter int unsigned ROM_AW       = 13
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        ce_pix,
  input  logic [8:0]                  hc,
  input  logic [8:0]                  vc,
  output logic [$clog2(NUM_SPR)-1:0]  spr_addr,
  input  logic [7:0]                  spr_y,
  input  logic [7:0]                  spr_x,
  input  logic [7:0]                  spr_code,
  input  logic [7:0]                  spr_attr,
  output logic [ROM_AW-1:0]           rom_addr,
  input  logic [7:0]                  rom_data1,
  input  logic [7:0]                  rom_data2,
  input  logic [7:0]                  rd_x,
  output logic [COL_BITS+1:0]         rd_pix,
  output logic                        overflow
);

  localparam int unsigned IdxW = $clog2(NUM_SPR);
  localparam int unsigned PixW = COL_BITS + 2;
  localparam int unsigned CntW = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [2:0] {
    StIdle, StEvalAddr, StEvalData, StFetchAddr, StFetchData, StDraw, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          x_q, x_d;
  logic                hflip_q, hflip_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [7:0]          d1_q, d1_d, d2_q, d2_d;
  logic [2:0]          px_q, px_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [PixW-1:0]     rd_pix_q;

  logic [PixW-1:0]     bank0 [256];
  logic [PixW-1:0]     bank1 [256];

  logic [7:0]  tgt;
  logic [7:0]  row_full;
  logic        hit;
  logic        line_start;
  logic        last_idx;
  logic [11:0] rom_addr_full;
  logic [2:0]  bit_idx;
  logic [1:0]  pix_val;
  logic [7:0]  wr_col;
  logic        build_bank;
  logic        disp_bank;
  logic [PixW-1:0] existing;
  logic [PixW-1:0] build_val;
  logic        build_we;
  logic        rd_en;

  logic unused_in;
  assign unused_in = ^{spr_attr[5:4], vc[8]};

  assign tgt        = vc[7:0] + 8'd1;
  assign row_full   = tgt - spr_y;
  assign hit        = (row_full < 8'd8);
  assign line_start = ce_pix && (hc == 9'd0);
  assign last_idx   = (idx_q == IdxW'(NUM_SPR - 1));
  assign build_bank = tgt[0];
  assign disp_bank  = vc[0];

  assign rom_addr_full = {spr_attr[3], spr_code, row_full[2:0] ^ {3{spr_attr[6]}}};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    x_d        = x_q;
    hflip_d    = hflip_q;
    col_d      = col_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    px_d       = px_q;
    rom_addr_d = rom_addr_q;
    if (line_start) begin
      // A new line always restarts the build, even mid-sprite.
      state_d = StEvalAddr;
      idx_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StEvalAddr: state_d = StEvalData;
        StEvalData: begin
          if (hit) begin
            if (cnt_q == CntW'(MAX_PER_LINE)) begin
              ovf_d   = 1'b1;
              state_d = StDone;
            end else begin
              x_d        = spr_x;
              hflip_d    = spr_attr[7];
              col_d      = spr_attr[COL_BITS-1:0];
              rom_addr_d = ROM_AW'(rom_addr_full);
              state_d    = StFetchAddr;
            end
          end else if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StEvalAddr;
          end
        end
        StFetchAddr: state_d = StFetchData;
        StFetchData: begin
          d1_d    = rom_data1;
          d2_d    = rom_data2;
          cnt_d   = cnt_q + CntW'(1);
          px_d    = 3'd0;
          state_d = StDraw;
        end
        StDraw: begin
          px_d = px_q + 3'd1;
          if (px_q == 3'd7) begin
            if (last_idx) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              state_d = StEvalAddr;
            end
          end
        end
        StIdle, StDone: state_d = state_q;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      x_q        <= '0;
      hflip_q    <= 1'b0;
      col_q      <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      px_q       <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      x_q        <= x_d;
      hflip_q    <= hflip_d;
      col_q      <= col_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      px_q       <= px_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Non-flipped tiles draw MSB first.
  assign bit_idx   = hflip_q ? px_q : (3'd7 - px_q);
  assign pix_val   = {d1_q[bit_idx], d2_q[bit_idx]};
  assign wr_col    = x_q + {5'd0, px_q};
  assign existing  = build_bank ? bank1[wr_col] : bank0[wr_col];
  assign build_val = {col_q, pix_val};
  // An opaque entry already present belongs to a lower index, which has priority.
  assign build_we  = !reset && (state_q == StDraw) && (pix_val != 2'd0) &&
                     (existing[1:0] == 2'd0);
  assign rd_en     = ce_pix && !hc[8];

  // Build and display always target opposite banks, so each bank sees one writer per cycle.
  always_ff @(posedge clk_sys) begin
    if (build_we && !build_bank) begin
      bank0[wr_col] <= build_val;
    end else if (rd_en && !disp_bank) begin
      bank0[rd_x] <= '0;
    end
    if (build_we && build_bank) begin
      bank1[wr_col] <= build_val;
    end else if (rd_en && disp_bank) begin
      bank1[rd_x] <= '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_pix_q <= '0;
    end else if (rd_en) begin
      rd_pix_q <= disp_bank ? bank1[rd_x] : bank0[rd_x];
    end
  end

  assign spr_addr = idx_q;
  assign rom_addr = rom_addr_q;
  assign overflow = ovf_q;
  assign rd_pix   = rd_pix_q;

endmodule
